// File: rtl/countdown_timer_nbit_if.sv
// Control/status bundle for countdown_timer_nbit: the controller drives the
// load/run controls, the timer drives back count, busy and expired.
interface countdown_timer_nbit_if #(
  parameter int unsigned Width = 10
) ();
  logic             load;
  logic [Width-1:0] load_value;
  logic             start;
  logic             stop;
  logic             enable;
  logic             auto_reload;
  logic [Width-1:0] count_value;
  logic             busy;
  logic             expired;

  modport master (
    output load, load_value, start, stop, enable, auto_reload,
    input  count_value, busy, expired
  );

  modport slave (
    input  load, load_value, start, stop, enable, auto_reload,
    output count_value, busy, expired
  );
endinterface

// File: rtl/countdown_timer_nbit.sv
// Loadable down-counting timer: counts a loaded value to zero by Decrement per
// enabled cycle, pulses expired at terminal count, then stops or auto-reloads.
module countdown_timer_nbit #(
  parameter int unsigned Width     = 10,
  parameter int unsigned Decrement = 1,
  parameter int unsigned MaxLoad   = (2 ** Width) - 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  countdown_timer_nbit_if.slave tmr_io
);

  localparam logic [Width-1:0] MaxLoadW = Width'(MaxLoad);
  localparam logic [Width:0]   DecW     = (Width + 1)'(Decrement);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic [Width-1:0] count_q;
  logic [Width-1:0] reload_q;
  logic             expired_q;

  logic [Width-1:0] load_clamped;
  logic [Width:0]   count_dec;
  logic             terminal;

  assign load_clamped = (tmr_io.load_value > MaxLoadW) ? MaxLoadW : tmr_io.load_value;

  // Borrow out of the extra bit, or an exact zero, means count <= Decrement.
  assign count_dec = {1'b0, count_q} - DecW;
  assign terminal  = count_dec[Width] | (count_dec == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (tmr_io.load) begin
        count_q  <= load_clamped;
        reload_q <= load_clamped;
        state_q  <= StIdle;
      end else if (tmr_io.stop && (state_q == StRun)) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (tmr_io.start) begin
              if (count_q != '0) begin
                state_q <= StRun;
              end else begin
                expired_q <= 1'b1;
              end
            end
          end
          StRun: begin
            if (tmr_io.enable) begin
              if (!terminal) begin
                count_q <= count_dec[Width-1:0];
              end else begin
                expired_q <= 1'b1;
                if (tmr_io.auto_reload && (reload_q != '0)) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= StIdle;
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tmr_io.count_value = count_q;
  assign tmr_io.busy        = (state_q == StRun);
  assign tmr_io.expired     = expired_q;

endmodule

// File: tb/tb_countdown_timer_nbit.sv
// Bench for countdown_timer_nbit: two instances (D=1/full range, D=3/MaxLoad=500)
// share stimulus and are checked every cycle against a behavioural model.
module tb_countdown_timer_nbit;

  localparam int W     = 10;
  localparam int D0    = 1;
  localparam int MAX0  = 1023;
  localparam int D1    = 3;
  localparam int MAX1  = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         ld = 1'b0;
  logic [W-1:0] lv = '0;
  logic         st = 1'b0;
  logic         sp = 1'b0;
  logic         en = 1'b0;
  logic         ar = 1'b0;

  countdown_timer_nbit_if #(.Width(W)) if0 ();
  countdown_timer_nbit_if #(.Width(W)) if1 ();

  assign if0.load = ld;  assign if0.load_value = lv;  assign if0.start = st;
  assign if0.stop = sp;  assign if0.enable = en;      assign if0.auto_reload = ar;
  assign if1.load = ld;  assign if1.load_value = lv;  assign if1.start = st;
  assign if1.stop = sp;  assign if1.enable = en;      assign if1.auto_reload = ar;

  countdown_timer_nbit #(.Width(W), .Decrement(D0), .MaxLoad(MAX0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tmr_io(if0)
  );
  countdown_timer_nbit #(.Width(W), .Decrement(D1), .MaxLoad(MAX1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tmr_io(if1)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the timer's rules.
  typedef struct {
    int count;
    int reload;
    bit run;
    bit exp;
  } mstate_t;

  function automatic mstate_t step(input mstate_t s, input int dec, input int maxl);
    mstate_t n = s;
    n.exp = 1'b0;
    if (ld) begin
      n.count  = (int'(lv) > maxl) ? maxl : int'(lv);
      n.reload = n.count;
      n.run    = 1'b0;
    end else if (sp && s.run) begin
      n.run = 1'b0;
    end else if (!s.run) begin
      if (st && s.count == 0) n.exp = 1'b1;
      else if (st)            n.run = 1'b1;
    end else if (en) begin
      if (s.count > dec) begin
        n.count = s.count - dec;
      end else begin
        n.exp = 1'b1;
        if (ar && s.reload != 0) begin
          n.count = s.reload;
        end else begin
          n.count = 0;
          n.run   = 1'b0;
        end
      end
    end
    return n;
  endfunction

  mstate_t m0, m1;
  mstate_t zero_s;
  initial zero_s = '{count: 0, reload: 0, run: 1'b0, exp: 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '{count: 0, reload: 0, run: 1'b0, exp: 1'b0};
      m1 <= '{count: 0, reload: 0, run: 1'b0, exp: 1'b0};
    end else begin
      m0 <= step(m0, D0, MAX0);
      m1 <= step(m1, D1, MAX1);
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("m0_count",   int'(if0.count_value), m0.count);
      check("m0_busy",    int'(if0.busy),        int'(m0.run));
      check("m0_expired", int'(if0.expired),     int'(m0.exp));
      check("m1_count",   int'(if1.count_value), m1.count);
      check("m1_busy",    int'(if1.busy),        int'(m1.run));
      check("m1_expired", int'(if1.expired),     int'(m1.exp));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    ld = 1'b0; st = 1'b0; sp = 1'b0; en = 1'b0; ar = 1'b0;
  endtask

  task automatic do_load(input int v);
    ld = 1'b1; lv = W'(v);
    cyc();
    ld = 1'b0;
  endtask

  task automatic lit0(input string name, input int c, input int b, input int e);
    check({name, "_cnt"}, int'(if0.count_value), c);
    check({name, "_busy"}, int'(if0.busy), b);
    check({name, "_exp"}, int'(if0.expired), e);
  endtask

  task automatic lit1(input string name, input int c, input int b, input int e);
    check({name, "_cnt"}, int'(if1.count_value), c);
    check({name, "_busy"}, int'(if1.busy), b);
    check({name, "_exp"}, int'(if1.expired), e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    lit0("rst", 0, 0, 0);

    // Start with count 0 in IDLE: single expired pulse, no run.
    st = 1'b1; cyc(); st = 1'b0;
    lit0("start0", 0, 0, 1);
    cyc();
    lit0("start0_after", 0, 0, 0);

    // Reset mid-run takes effect with no clock edge.
    do_load(37);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    cyc(3);
    lit0("run37", 34, 1, 0);
    rst_n = 1'b0;
    #1;
    lit0("async_rst", 0, 0, 0);
    lit1("async_rst1", 0, 0, 0);
    #2 rst_n = 1'b1;
    cyc();
    lit0("post_rst", 0, 0, 0);

    // D=1 load 5: 5,5,4,3,2,1,0 with expired after the 1->0 edge.
    idle_inputs();
    do_load(5);
    lit0("ld5", 5, 0, 0);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    lit0("s5", 5, 1, 0);
    cyc(); lit0("s4", 4, 1, 0);
    cyc(3); lit0("s1", 1, 1, 0);
    cyc(); lit0("s0", 0, 0, 1);
    cyc(); lit0("s0_after", 0, 0, 0);

    // D=3 load 7: 7,4,1,0 with no wrap.
    idle_inputs();
    do_load(7);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    lit1("d3_7", 7, 1, 0);
    cyc(); lit1("d3_4", 4, 1, 0);
    cyc(); lit1("d3_1", 1, 1, 0);
    cyc(); lit1("d3_0", 0, 0, 1);
    cyc(); lit1("d3_hold", 0, 0, 0);

    // Auto-reload load 3: 3,2,1,3,2,1 with a pulse per reload.
    idle_inputs();
    ar = 1'b1;
    do_load(3);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    lit0("ar3", 3, 1, 0);
    cyc(2); lit0("ar1", 1, 1, 0);
    cyc(); lit0("ar_rl", 3, 1, 1);
    cyc(); lit0("ar2", 2, 1, 0);
    cyc(2); lit0("ar_rl2", 3, 1, 1);

    // Hold with enable low, stop, then resume.
    idle_inputs();
    do_load(10);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    cyc(); lit0("at9", 9, 1, 0);
    en = 1'b0; cyc(4);
    lit0("hold9", 9, 1, 0);
    sp = 1'b1; cyc(); sp = 1'b0;
    lit0("stop9", 9, 0, 0);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    lit0("resume9", 9, 1, 0);
    cyc(); lit0("resume8", 8, 1, 0);

    // Clamp on load during a run; load beats start on the same edge.
    idle_inputs();
    do_load(6);
    st = 1'b1; en = 1'b1; cyc(); st = 1'b0;
    lit1("run6", 6, 1, 0);
    do_load(1023);
    lit1("clamp", 500, 0, 0);
    lit0("noclamp", 1023, 0, 0);
    ld = 1'b1; lv = W'(20); st = 1'b1; cyc(); ld = 1'b0; st = 1'b0;
    lit1("ld_start", 20, 0, 0);

    // Randomised phase, checked by the model every cycle.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      lv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1023))
                                       : W'($urandom_range(0, 12));
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ((i % 97) == 0) ar = $urandom_range(0, 1) != 0;
      if (i == 1500) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc();
    end
    idle_inputs();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
